// File: rtl/decoder_pipelined_if.sv
// Valid/ready stream bundle for decoder_pipelined: select/mode/enable beats in, decoded masks out.
interface decoder_pipelined_if #(
  parameter int unsigned WIDTH = 32
);
  localparam int unsigned SEL_BITS = $clog2(WIDTH);

  logic                in_valid;
  logic                in_ready;
  logic [SEL_BITS-1:0] in_sel;
  logic [1:0]          in_mode;
  logic                in_enable;
  logic                out_valid;
  logic                out_ready;
  logic [WIDTH-1:0]    out_mask;

  modport master (
    output in_valid, in_sel, in_mode, in_enable, out_ready,
    input  in_ready, out_valid, out_mask
  );

  modport slave (
    input  in_valid, in_sel, in_mode, in_enable, out_ready,
    output in_ready, out_valid, out_mask
  );
endinterface

// File: rtl/decoder_pipelined.sv
// Pipelined binary-to-mask decoder; select bits are resolved MSB-first across the stages and the
// last stage applies the one-hot / thermometer / all-ones mode and the enable.
module decoder_pipelined #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned PIPE_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  decoder_pipelined_if.slave bus
);
  localparam int unsigned SEL_BITS = $clog2(WIDTH);
  localparam int unsigned BPS      = (SEL_BITS + PIPE_STAGES - 1) / PIPE_STAGES;

  if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("decoder_pipelined: WIDTH must be a power of 2 and >= 2");
  end
  if (PIPE_STAGES < 1 || PIPE_STAGES > SEL_BITS) begin : g_bad_pipe
    $error("decoder_pipelined: PIPE_STAGES must be in 1..clog2(WIDTH)");
  end

  typedef enum logic [1:0] {
    MODE_ONEHOT   = 2'b00,
    MODE_THERM_LO = 2'b01,
    MODE_THERM_HI = 2'b10,
    MODE_ALL      = 2'b11
  } mode_e;

  function automatic int unsigned resolved(input int unsigned k);
    return (k * BPS > SEL_BITS) ? SEL_BITS : k * BPS;
  endfunction

  // Element k of each chain array is the input seen by stage k.
  logic [PIPE_STAGES-1:0] v_all;
  logic [PIPE_STAGES-1:0] load;
  logic [SEL_BITS-1:0]    c_sel  [PIPE_STAGES];
  mode_e                  c_mode [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] c_en;
  logic [WIDTH-1:0]       c_mask [PIPE_STAGES+1];

  assign c_sel[0]  = bus.in_sel;
  assign c_mode[0] = mode_e'(bus.in_mode);
  assign c_en[0]   = bus.in_enable;
  assign c_mask[0] = WIDTH'(1);

  // Stage k may load when empty or when everything downstream of it moves this cycle.
  always_comb begin
    logic nxt;
    nxt  = bus.out_ready;
    load = '0;
    for (int unsigned i = 0; i < PIPE_STAGES; i++) begin
      nxt                        = !v_all[PIPE_STAGES-1-i] | nxt;
      load[PIPE_STAGES-1-i]      = nxt;
    end
  end

  assign bus.in_ready  = load[0];
  assign bus.out_valid = v_all[PIPE_STAGES-1];
  assign bus.out_mask  = c_mask[PIPE_STAGES];

  for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
    localparam int unsigned RN = resolved(k + 1);
    localparam int unsigned B  = RN - resolved(k);

    logic             vin;
    logic             v_q;
    logic [WIDTH-1:0] part;
    logic [WIDTH-1:0] mask_d;
    logic [WIDTH-1:0] mask_q;

    if (k == 0) begin : g_vin0
      assign vin = bus.in_valid;
    end else begin : g_vinn
      assign vin = v_all[k-1];
    end

    // Partial one-hot over the top RN select bits: each previous bit fans out to 2^B children.
    always_comb begin
      int unsigned c;
      c    = (32'(c_sel[k]) >> (SEL_BITS - RN)) % (32'd1 << B);
      part = '0;
      for (int unsigned j = 0; j < WIDTH; j++) begin
        part[j] = c_mask[k][j >> B] && ((j % (32'd1 << B)) == c);
      end
    end

    if (k == PIPE_STAGES - 1) begin : g_final
      always_comb begin
        logic             acc_lo;
        logic             acc_hi;
        logic [WIDTH-1:0] lo;
        logic [WIDTH-1:0] hi;
        acc_lo = 1'b0;
        acc_hi = 1'b0;
        lo     = '0;
        hi     = '0;
        for (int unsigned j = 0; j < WIDTH; j++) begin
          acc_hi             = acc_hi | part[j];
          hi[j]              = acc_hi;
          acc_lo             = acc_lo | part[WIDTH-1-j];
          lo[WIDTH-1-j]      = acc_lo;
        end
        case (c_mode[k])
          MODE_ONEHOT:   mask_d = part;
          MODE_THERM_LO: mask_d = lo;
          MODE_THERM_HI: mask_d = hi;
          default:       mask_d = '1;
        endcase
        if (!c_en[k]) mask_d = '0;
      end
    end else begin : g_fwd
      logic [SEL_BITS-1:0] sel_q;
      mode_e               mode_q;
      logic                en_q;

      assign mask_d = part;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          sel_q  <= '0;
          mode_q <= MODE_ONEHOT;
          en_q   <= 1'b0;
        end else if (load[k] && vin) begin
          sel_q  <= c_sel[k];
          mode_q <= c_mode[k];
          en_q   <= c_en[k];
        end
      end

      assign c_sel[k+1]  = sel_q;
      assign c_mode[k+1] = mode_q;
      assign c_en[k+1]   = en_q;
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        v_q    <= 1'b0;
        mask_q <= '0;
      end else if (load[k]) begin
        v_q <= vin;
        if (vin) mask_q <= mask_d;
      end
    end

    assign v_all[k]    = v_q;
    assign c_mask[k+1] = mask_q;
  end
endmodule
